// File: rtl/rply_bias_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rply_bias_pkg : state encoding and default sizing for the bias sequencer  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package rply_bias_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_KICK   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ON     = 3'd3,
    ST_FLT    = 3'd4
  } bias_state_e;

  localparam int c_N_OUT_DEF          = 6;
  localparam int c_KICK_CYCLES_DEF    = 8;
  localparam int c_SETTLE_CYCLES_DEF  = 1024;
  localparam int c_TIMEOUT_CYCLES_DEF = 4096;
  localparam int c_SYNC_STAGES_DEF    = 2;

endpackage : rply_bias_pkg
`default_nettype wire

// File: rtl/rply_bias_sync.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rply_bias_sync : multi-flop synchroniser for the asynchronous BIAS_OK     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module rply_bias_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CK,
  input  logic RST,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule : rply_bias_sync
`default_nettype wire

// File: rtl/rply_bias_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rply_bias_ctrl : power-up sequencer and per-branch 4-phase grant logic    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module rply_bias_ctrl
  import rply_bias_pkg::*;
#(
  parameter int N_OUT          = c_N_OUT_DEF,
  parameter int KICK_CYCLES    = c_KICK_CYCLES_DEF,
  parameter int SETTLE_CYCLES  = c_SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF,
  parameter int SYNC_STAGES    = c_SYNC_STAGES_DEF
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic             BIAS_OK,
  input  logic [N_OUT-1:0] REQ,
  output logic [N_OUT-1:0] ACK,
  output logic [N_OUT-1:0] OUT_EN,
  output logic             PWRUP_N,
  output logic             STARTUP,
  output logic             READY,
  output logic             FAULT
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] c_KICK_LAST    = CNT_W'(KICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bias_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ok_s;

  logic pwrup_n_q, pwrup_n_d;
  logic startup_q, startup_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;
  logic [N_OUT-1:0] out_en_q, out_en_d;
  logic [N_OUT-1:0] ack_q, ack_d;
  logic hs_active;

  rply_bias_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CK     (CK),
    .RST    (RST),
    .async_i(BIAS_OK),
    .sync_o (ok_s)
  );

  // Dropping EN overrides every other transition out of an active state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF: begin
        if (EN) state_d = ST_KICK;
      end
      ST_KICK: begin
        if (!EN)                       state_d = ST_OFF;
        else if (cnt_q == c_KICK_LAST) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!EN)                                  state_d = ST_OFF;
        else if (cnt_q >= c_SETTLE_LAST && ok_s)  state_d = ST_ON;
        else if (cnt_q == c_TIMEOUT_LAST)         state_d = ST_FLT;
      end
      ST_ON: begin
        if (!EN)       state_d = ST_OFF;
        else if (!ok_s) state_d = ST_FLT;
      end
      ST_FLT: begin
        if (!EN) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)   cnt_d = '0;
    else if (cnt_q != c_CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    pwrup_n_d = 1'b1;
    startup_d = 1'b0;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    unique case (state_d)
      ST_KICK: begin
        pwrup_n_d = 1'b0;
        startup_d = 1'b1;
      end
      ST_SETTLE: pwrup_n_d = 1'b0;
      ST_ON: begin
        pwrup_n_d = 1'b0;
        ready_d   = 1'b1;
      end
      ST_FLT:  fault_d = 1'b1;
      default: pwrup_n_d = 1'b1;
    endcase
  end

  // Grants only advance while ON persists; any exit clears them on that edge.
  assign hs_active = (state_q == ST_ON) && (state_d == ST_ON);

  for (genvar i = 0; i < N_OUT; i++) begin : g_branch
    assign out_en_d[i] = !hs_active                 ? 1'b0 :
                         (REQ[i]  && !out_en_q[i])  ? 1'b1 :
                         (!REQ[i] && ack_q[i])      ? 1'b0 :
                                                      out_en_q[i];
    assign ack_d[i]    = hs_active ? out_en_q[i] : 1'b0;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      pwrup_n_q <= 1'b1;
      startup_q <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      out_en_q  <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pwrup_n_q <= pwrup_n_d;
      startup_q <= startup_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      out_en_q  <= out_en_d;
      ack_q     <= ack_d;
    end
  end

  assign PWRUP_N = pwrup_n_q;
  assign STARTUP = startup_q;
  assign READY   = ready_q;
  assign FAULT   = fault_q;
  assign OUT_EN  = out_en_q;
  assign ACK     = ack_q;

endmodule : rply_bias_ctrl
`default_nettype wire
